// File: rtl/hmm_pkg.sv
// Shared constants and fixed-point helpers for the HMM forward engine.
// Probabilities are unsigned Q0.DATA_PREC fractions carried in 32-bit helpers.
package hmm_pkg;

    localparam int HIDDEN_STATES_DEF   = 4;
    localparam int OBSERVED_STATES_DEF = 4;
    localparam int DATA_PREC_DEF       = 16;

    typedef logic [DATA_PREC_DEF-1:0] prob_t;

    // Q0.prec product, truncated toward zero.
    function automatic logic [31:0] mul(
        input logic [31:0] a,
        input logic [31:0] b,
        input int unsigned prec
    );
        logic [63:0] p;
        p = {32'd0, a} * {32'd0, b};
        p = p >> prec;
        return p[31:0];
    endfunction

    // Sum clamped to the largest Q0.prec value (all ones).
    function automatic logic [31:0] sat_add(
        input logic [63:0] a,
        input logic [63:0] b,
        input int unsigned prec
    );
        logic [63:0] s;
        logic [63:0] lim;
        s   = a + b;
        lim = (64'd1 << prec) - 64'd1;
        return (s > lim) ? lim[31:0] : s[31:0];
    endfunction

endpackage

// File: rtl/hmm_mac_unit.sv
// Registered multiply-accumulate for one alpha term per cycle.
// Ports: clk/rst, clr/en control acc; first selects pi*emm over alpha*trans*emm; sum_sat = sat(acc+term).
module hmm_mac_unit
    import hmm_pkg::*;
#(
    parameter int DATA_PREC = DATA_PREC_DEF,
    parameter int ACC_W     = DATA_PREC + 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr,
    input  logic                 en,
    input  logic                 first,
    input  logic [DATA_PREC-1:0] alpha_k,
    input  logic [DATA_PREC-1:0] trans_kj,
    input  logic [DATA_PREC-1:0] emm_jo,
    input  logic [DATA_PREC-1:0] pi_j,
    output logic [DATA_PREC-1:0] sum_sat
);

    logic [DATA_PREC-1:0] te;
    logic [DATA_PREC-1:0] term;
    logic [ACC_W-1:0]     acc;

    always_comb begin
        te = DATA_PREC'(mul(32'(trans_kj), 32'(emm_jo), DATA_PREC));
        if (first)
            term = DATA_PREC'(mul(32'(pi_j), 32'(emm_jo), DATA_PREC));
        else
            term = DATA_PREC'(mul(32'(alpha_k), 32'(te), DATA_PREC));
        sum_sat = DATA_PREC'(sat_add(64'(acc), 64'(term), DATA_PREC));
    end

    // acc holds at most H-1 partial terms, so ACC_W never overflows.
    always_ff @(posedge clk) begin
        if (rst || clr)
            acc <= '0;
        else if (en)
            acc <= acc + ACC_W'(term);
    end

endmodule

// File: rtl/hmm_forward_engine.sv
// Streaming HMM forward algorithm: one MAC per cycle, alpha vector per symbol.
// Ports: obs_* in (valid/ready), alpha_* out (valid/ready), lik_valid/likelihood at sequence end.
module hmm_forward_engine
    import hmm_pkg::*;
#(
    parameter int HIDDEN_STATES   = HIDDEN_STATES_DEF,
    parameter int OBSERVED_STATES = OBSERVED_STATES_DEF,
    parameter int DATA_PREC       = DATA_PREC_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic [HIDDEN_STATES-1:0][HIDDEN_STATES-1:0][DATA_PREC-1:0]   trans,
    input  logic [HIDDEN_STATES-1:0][OBSERVED_STATES-1:0][DATA_PREC-1:0] emm,
    input  logic [HIDDEN_STATES-1:0][DATA_PREC-1:0] stationary_distribution,
    input  logic obs_valid,
    output logic obs_ready,
    input  logic [$clog2(OBSERVED_STATES)-1:0] obs,
    input  logic obs_last,
    output logic alpha_valid,
    input  logic alpha_ready,
    output logic [HIDDEN_STATES-1:0][DATA_PREC-1:0] alpha_out,
    output logic alpha_last,
    output logic lik_valid,
    output logic [DATA_PREC-1:0] likelihood
);

    localparam int JW    = $clog2(HIDDEN_STATES);
    localparam int OW    = $clog2(OBSERVED_STATES);
    localparam int ACC_W = DATA_PREC + JW + 1;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_COMPUTE = 2'd1;
    localparam logic [1:0] S_OUT     = 2'd2;
    localparam logic [1:0] S_LIK     = 2'd3;

    logic [1:0]    state;
    logic          first;
    logic          last_q;
    logic [OW-1:0] obs_q;
    logic [JW-1:0] j;
    logic [JW-1:0] k;
    logic [HIDDEN_STATES-1:0][DATA_PREC-1:0] nxt;
    logic [HIDDEN_STATES-1:0][DATA_PREC-1:0] alpha;

    logic [DATA_PREC-1:0] emm_sel;
    logic [DATA_PREC-1:0] sum_sat;
    logic [DATA_PREC-1:0] lik_sum;
    logic [31:0]          lik_acc;
    logic                 j_last;
    logic                 k_last;
    logic                 mac_clr;
    logic                 mac_en;

    assign j_last = (j == JW'(HIDDEN_STATES - 1));
    assign k_last = (k == JW'(HIDDEN_STATES - 1));

    // Symbols outside the alphabet match no column and see emission 0.
    always_comb begin
        emm_sel = '0;
        for (int o = 0; o < OBSERVED_STATES; o++)
            if (obs_q == OW'(o))
                emm_sel = emm[j][o];
    end

    always_comb begin
        lik_acc = '0;
        for (int h = 0; h < HIDDEN_STATES; h++)
            lik_acc = sat_add(64'(lik_acc), 64'(nxt[h]), DATA_PREC);
        lik_sum = DATA_PREC'(lik_acc);
    end

    assign mac_clr = (state == S_IDLE && obs_valid) ||
                     (state == S_COMPUTE && !first && k_last);
    assign mac_en  = (state == S_COMPUTE) && !first;

    hmm_mac_unit #(
        .DATA_PREC (DATA_PREC),
        .ACC_W     (ACC_W)
    ) u_mac (
        .clk      (clk),
        .rst      (rst),
        .clr      (mac_clr),
        .en       (mac_en),
        .first    (first),
        .alpha_k  (alpha[k]),
        .trans_kj (trans[k][j]),
        .emm_jo   (emm_sel),
        .pi_j     (stationary_distribution[j]),
        .sum_sat  (sum_sat)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            first      <= 1'b1;
            last_q     <= 1'b0;
            obs_q      <= '0;
            j          <= '0;
            k          <= '0;
            nxt        <= '0;
            alpha      <= '0;
            likelihood <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (obs_valid) begin
                        obs_q  <= obs;
                        last_q <= obs_last;
                        j      <= '0;
                        k      <= '0;
                        state  <= S_COMPUTE;
                    end
                end
                S_COMPUTE: begin
                    // First step: acc stays 0, so sum_sat is just pi*emm.
                    if (first || k_last) begin
                        nxt[j] <= sum_sat;
                        k      <= '0;
                        j      <= j + 1'b1;
                        if (j_last)
                            state <= S_OUT;
                    end else begin
                        k <= k + 1'b1;
                    end
                end
                S_OUT: begin
                    if (alpha_ready) begin
                        alpha <= nxt;
                        if (last_q) begin
                            likelihood <= lik_sum;
                            state      <= S_LIK;
                        end else begin
                            first <= 1'b0;
                            state <= S_IDLE;
                        end
                    end
                end
                S_LIK: begin
                    first <= 1'b1;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign obs_ready   = (state == S_IDLE);
    assign alpha_valid = (state == S_OUT);
    assign alpha_last  = (state == S_OUT) && last_q;
    assign alpha_out   = nxt;
    assign lik_valid   = (state == S_LIK);

endmodule

// File: tb/tb_hmm_forward_engine.sv
// Scoreboard bench for hmm_forward_engine: H=2/O=2/P=8 and H=4/O=3/P=16 instances.
// A reference forward model pushes expected alpha/likelihood values on every accepted symbol.
module tb_hmm_forward_engine;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int tr[4][4];
    int em[4][4];
    int pv[4];

    logic [1:0][1:0][7:0] a_trans;
    logic [1:0][1:0][7:0] a_emm;
    logic [1:0][7:0]      a_pi;
    logic a_obs_valid, a_obs_ready, a_obs, a_obs_last;
    logic a_alpha_valid, a_alpha_ready, a_alpha_last, a_lik_valid;
    logic [1:0][7:0] a_alpha_out;
    logic [7:0]      a_likelihood;

    logic [3:0][3:0][15:0] b_trans;
    logic [3:0][2:0][15:0] b_emm;
    logic [3:0][15:0]      b_pi;
    logic b_obs_valid, b_obs_ready, b_obs_last;
    logic [1:0] b_obs;
    logic b_alpha_valid, b_alpha_ready, b_alpha_last, b_lik_valid;
    logic [3:0][15:0] b_alpha_out;
    logic [15:0]      b_likelihood;

    always_comb begin
        a_trans = '0;
        a_emm   = '0;
        a_pi    = '0;
        b_trans = '0;
        b_emm   = '0;
        b_pi    = '0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (r < 2 && c < 2) begin
                    a_trans[r][c] = 8'(tr[r][c]);
                    a_emm[r][c]   = 8'(em[r][c]);
                end
                b_trans[r][c] = 16'(tr[r][c]);
                if (c < 3)
                    b_emm[r][c] = 16'(em[r][c]);
            end
            if (r < 2)
                a_pi[r] = 8'(pv[r]);
            b_pi[r] = 16'(pv[r]);
        end
    end

    hmm_forward_engine #(
        .HIDDEN_STATES (2), .OBSERVED_STATES (2), .DATA_PREC (8)
    ) u_a (
        .clk (clk), .rst (rst),
        .trans (a_trans), .emm (a_emm), .stationary_distribution (a_pi),
        .obs_valid (a_obs_valid), .obs_ready (a_obs_ready),
        .obs (a_obs), .obs_last (a_obs_last),
        .alpha_valid (a_alpha_valid), .alpha_ready (a_alpha_ready),
        .alpha_out (a_alpha_out), .alpha_last (a_alpha_last),
        .lik_valid (a_lik_valid), .likelihood (a_likelihood)
    );

    hmm_forward_engine #(
        .HIDDEN_STATES (4), .OBSERVED_STATES (3), .DATA_PREC (16)
    ) u_b (
        .clk (clk), .rst (rst),
        .trans (b_trans), .emm (b_emm), .stationary_distribution (b_pi),
        .obs_valid (b_obs_valid), .obs_ready (b_obs_ready),
        .obs (b_obs), .obs_last (b_obs_last),
        .alpha_valid (b_alpha_valid), .alpha_ready (b_alpha_ready),
        .alpha_out (b_alpha_out), .alpha_last (b_alpha_last),
        .lik_valid (b_lik_valid), .likelihood (b_likelihood)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    logic [63:0] q_alpha[$];
    logic        q_last[$];
    logic [63:0] q_lik[$];
    bit          m_first = 1'b1;
    longint      m_alpha[4];

    function automatic longint mulm(input longint a, input longint b, input int prec);
        return (a * b) >> prec;
    endfunction

    task automatic model_step(input int h, input int o, input int prec, input int ob, input bit last);
        longint mask;
        longint nx[4];
        longint s;
        longint e;
        logic [63:0] pk;
        mask = (longint'(1) << prec) - 1;
        pk   = '0;
        for (int j = 0; j < 4; j++) nx[j] = 0;
        for (int j = 0; j < h; j++) begin
            e = (ob < o) ? (longint'(em[j][ob]) & mask) : 0;
            if (m_first) begin
                s = mulm(longint'(pv[j]) & mask, e, prec);
            end else begin
                s = 0;
                for (int k = 0; k < h; k++)
                    s += mulm(m_alpha[k], mulm(longint'(tr[k][j]) & mask, e, prec), prec);
            end
            if (s > mask) s = mask;
            nx[j] = s;
            pk = pk | (64'(s) << (j * prec));
        end
        q_alpha.push_back(pk);
        q_last.push_back(last);
        for (int j = 0; j < 4; j++) m_alpha[j] = nx[j];
        if (last) begin
            s = 0;
            for (int j = 0; j < h; j++) s += nx[j];
            if (s > mask) s = mask;
            q_lik.push_back(64'(s));
            m_first = 1'b1;
        end else begin
            m_first = 1'b0;
        end
    endtask

    task automatic sb_alpha(input string tag, input logic [63:0] got, input logic last);
        logic [63:0] e;
        logic        l;
        if (q_alpha.size() == 0) begin
            check({tag, "_unexpected"}, 64'(q_alpha.size()), 64'd1);
        end else begin
            e = q_alpha.pop_front();
            l = q_last.pop_front();
            check(tag, got, e);
            check({tag, "_last"}, 64'(last), 64'(l));
        end
    endtask

    task automatic sb_lik(input string tag, input logic [63:0] got);
        if (q_lik.size() == 0)
            check({tag, "_unexpected"}, 64'(q_lik.size()), 64'd1);
        else
            check(tag, got, q_lik.pop_front());
    endtask

    always @(negedge clk) begin
        if (a_alpha_valid && a_alpha_ready) sb_alpha("a_alpha", 64'(a_alpha_out), a_alpha_last);
        if (b_alpha_valid && b_alpha_ready) sb_alpha("b_alpha", 64'(b_alpha_out), b_alpha_last);
        if (a_lik_valid) sb_lik("a_lik", 64'(a_likelihood));
        if (b_lik_valid) sb_lik("b_lik", 64'(b_likelihood));
    end

    task automatic send_a(input int ob, input bit last);
        int n;
        a_obs       = ob[0];
        a_obs_last  = last;
        a_obs_valid = 1'b1;
        n = 0;
        while (!a_obs_ready && n < 400) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 400) begin
            check("a_accept_timeout", 64'(n), 64'd0);
        end else begin
            model_step(2, 2, 8, ob, last);
            @(posedge clk); #1;
        end
        a_obs_valid = 1'b0;
    endtask

    task automatic send_b(input int ob, input bit last);
        int n;
        b_obs       = ob[1:0];
        b_obs_last  = last;
        b_obs_valid = 1'b1;
        n = 0;
        while (!b_obs_ready && n < 400) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 400) begin
            check("b_accept_timeout", 64'(n), 64'd0);
        end else begin
            model_step(4, 3, 16, ob, last);
            @(posedge clk); #1;
        end
        b_obs_valid = 1'b0;
    endtask

    task automatic wait_alpha(input bit sel_b, output int n);
        n = 0;
        while (!(sel_b ? b_alpha_valid : a_alpha_valid) && n < 400) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 400) check("alpha_timeout", 64'(n), 64'd0);
    endtask

    task automatic wait_lik(input bit sel_b, output int n);
        n = 0;
        while (!(sel_b ? b_lik_valid : a_lik_valid) && n < 400) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 400) check("lik_timeout", 64'(n), 64'd0);
        @(posedge clk); #1;
    endtask

    task automatic set_all(input int v);
        for (int r = 0; r < 4; r++) begin
            pv[r] = v;
            for (int c = 0; c < 4; c++) begin
                tr[r][c] = v;
                em[r][c] = v;
            end
        end
    endtask

    task automatic set_rand(input int maxv);
        for (int r = 0; r < 4; r++) begin
            pv[r] = int'($urandom_range(0, maxv));
            for (int c = 0; c < 4; c++) begin
                tr[r][c] = int'($urandom_range(0, maxv));
                em[r][c] = int'($urandom_range(0, maxv));
            end
        end
    endtask

    logic [15:0] saved;
    int n;
    int len;

    initial begin
        a_obs_valid = 0; a_obs = 0; a_obs_last = 0; a_alpha_ready = 1;
        b_obs_valid = 0; b_obs = 0; b_obs_last = 0; b_alpha_ready = 1;
        set_all(0);
        repeat (3) @(posedge clk);
        #1;
        check("rst_obs_ready", 64'(a_obs_ready), 64'd1);
        check("rst_alpha_valid", 64'(a_alpha_valid), 64'd0);
        check("rst_alpha_last", 64'(a_alpha_last), 64'd0);
        check("rst_lik_valid", 64'(a_lik_valid), 64'd0);
        check("rst_likelihood", 64'(a_likelihood), 64'd0);
        check("rst_alpha_out", 64'(a_alpha_out), 64'd0);
        check("rst_b_obs_ready", 64'(b_obs_ready), 64'd1);
        rst = 0;

        set_all(8'h80);
        send_a(0, 1);
        wait_alpha(0, n);
        check("len1_latency", 64'(n), 64'd2);
        wait_lik(0, n);

        send_a(0, 0);
        wait_alpha(0, n);
        check("len2_lat_first", 64'(n), 64'd2);
        send_a(1, 1);
        wait_alpha(0, n);
        check("len2_lat_second", 64'(n), 64'd4);
        wait_lik(0, n);

        set_all(8'hFF);
        send_a(0, 0);
        send_a(1, 1);
        wait_lik(0, n);

        set_rand(255);
        a_alpha_ready = 0;
        send_a(1, 0);
        wait_alpha(0, n);
        saved       = 16'(a_alpha_out);
        a_obs       = 1'b0;
        a_obs_last  = 1'b1;
        a_obs_valid = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            check("bp_valid", 64'(a_alpha_valid), 64'd1);
            check("bp_data", 64'(a_alpha_out), 64'(saved));
            check("bp_obs_ready", 64'(a_obs_ready), 64'd0);
        end
        a_obs_valid   = 1'b0;
        a_alpha_ready = 1;
        send_a(0, 1);
        wait_lik(0, n);

        set_all(8'h80);
        send_a(0, 0);
        send_a(1, 1);
        @(posedge clk); #1;
        rst = 1;
        @(posedge clk); #1;
        rst = 0;
        check("rstmid_obs_ready", 64'(a_obs_ready), 64'd1);
        check("rstmid_alpha_valid", 64'(a_alpha_valid), 64'd0);
        q_alpha.delete();
        q_last.delete();
        q_lik.delete();
        m_first = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        send_a(0, 1);
        wait_lik(0, n);

        for (int s = 0; s < 4; s++) begin
            set_rand(255);
            len = int'($urandom_range(1, 3));
            for (int t = 0; t < len; t++)
                send_a(int'($urandom_range(0, 1)), t == len - 1);
            wait_lik(0, n);
        end

        set_all(16'h8000);
        send_b(0, 1);
        wait_alpha(1, n);
        check("b_len1_latency", 64'(n), 64'd4);
        wait_lik(1, n);

        send_b(3, 1);
        wait_lik(1, n);

        set_rand(65535);
        send_b(int'($urandom_range(0, 2)), 0);
        send_b(int'($urandom_range(0, 2)), 0);
        wait_alpha(1, n);
        check("b_lat_later", 64'(n), 64'd16);
        send_b(int'($urandom_range(0, 2)), 1);
        wait_lik(1, n);

        repeat (5) @(posedge clk);
        #1;
        check("sb_drain", 64'(q_alpha.size() + q_lik.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
